// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with a one-byte holding register and sticky error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around every bit centre.
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       sys_clk_i,
   input  logic       sys_rstn_i,
   input  logic       uart_rx_i,
   output logic [7:0] uart_dat_o,
   output logic       uart_valid_o,
   input  logic       uart_rd_i,
   output logic       uart_ferr_o,
   output logic       uart_ovf_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   // One spare counter bit so that the majority look-ahead (cnt + 2) never aliases a decision count.
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
`ifdef UART_RX_MAJORITY_EN
   localparam int START_DEC = CLKS_PER_BIT / 2;
`else
   localparam int START_DEC = CLKS_PER_BIT / 2 - 1;
`endif
   localparam int BIT_DEC = CLKS_PER_BIT - 1;

   localparam logic [CW-1:0] START_END = CW'(START_DEC);
   localparam logic [CW-1:0] BIT_END   = CW'(BIT_DEC);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          armed_q, armed_d;
   logic          rx_meta, rx_s;
   logic [CW-1:0] dec_cnt;
   logic          at_dec;
   logic          sample;
   logic          load;
   logic          ferr_set;

   // Synchroniser resets to the idle-line level so reset never looks like a start bit.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx_i;
         rx_s    <= rx_meta;
      end
   end

   assign dec_cnt = (state_q == START) ? START_END : BIT_END;
   assign at_dec  = (cnt_q == dec_cnt);

`ifdef UART_RX_MAJORITY_EN
   logic s0_q, s1_q;

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         s0_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if ((cnt_q + CW'(2)) == dec_cnt) s0_q <= rx_s;
         if ((cnt_q + CW'(1)) == dec_cnt) s1_q <= rx_s;
      end
   end

   assign sample = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         armed_q <= armed_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      armed_d  = armed_q;
      load     = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               armed_d = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (at_dec) begin
               if (!sample) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (at_dec) begin
               cnt_d          = '0;
               shreg_d[bit_q] = sample;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (at_dec) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (sample) load     = 1'b1;
               else        ferr_set = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A load beats a same-cycle read; a framing-error set beats a same-cycle clear.
   always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
      if (!sys_rstn_i) begin
         uart_dat_o   <= '0;
         uart_valid_o <= 1'b0;
         uart_ferr_o  <= 1'b0;
         uart_ovf_o   <= 1'b0;
      end else begin
         if (load) begin
            uart_dat_o   <= shreg_q;
            uart_valid_o <= 1'b1;
            if (uart_rd_i)         uart_ovf_o <= 1'b0;
            else if (uart_valid_o) uart_ovf_o <= 1'b1;
         end else if (uart_rd_i) begin
            uart_valid_o <= 1'b0;
            uart_ovf_o   <= 1'b0;
         end
         if (ferr_set)       uart_ferr_o <= 1'b1;
         else if (uart_rd_i) uart_ferr_o <= 1'b0;
      end
   end

endmodule
